// File: rtl/qcl_reset_pkg.sv
// qcl_reset_pkg: shared state encoding and parameter floors for the reset sequencer.
// STAGGER_S exists only when QCL_RESET_SEQ_STAGGER_EN is defined.
package qcl_reset_pkg;
  typedef enum logic [1:0] {
    RESET_S,
    HOLD_S,
`ifdef QCL_RESET_SEQ_STAGGER_EN
    STAGGER_S,
`endif
    RUN_S
  } qcl_reset_state_e;
  localparam int qcl_reset_min_sync_stages_gp = 2;
  localparam int qcl_reset_min_hold_gp = 1;
endpackage

// File: rtl/qcl_sync_chain.sv
// qcl_sync_chain: single-bit reset-release synchronizer, async set to 1, shifts in 0.
// sync_d_o is the value the last stage takes on the next edge, for edge-exact release.
module qcl_sync_chain #(
  parameter int sync_stages_p = 2
) (
  input  logic clk_i,
  input  logic reset_i,
  output logic sync_o,
  output logic sync_d_o
);
  logic [sync_stages_p-1:0] chain_q;
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) chain_q <= '1;
    else chain_q <= {chain_q[sync_stages_p-2:0], 1'b0};
  assign sync_o   = chain_q[sync_stages_p-1];
  assign sync_d_o = chain_q[sync_stages_p-2];
endmodule

// File: rtl/qcl_reset_sequencer.sv
// qcl_reset_sequencer: async-assert / sync-release reset bus with hold window and sw re-reset.
// QCL_RESET_SEQ_STAGGER_EN releases reset_o bits stagger_p cycles apart.
module qcl_reset_sequencer
  import qcl_reset_pkg::*;
#(
  parameter int sync_stages_p = 2,
  parameter int hold_cycles_p = 16,
  parameter int num_out_p     = 1,
  parameter int stagger_p     = 4
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 sw_reset_v_i,
  output logic                 sw_reset_ready_o,
  output logic [num_out_p-1:0] reset_o,
  output logic                 reset_done_o
);
  localparam int cnt_w = $clog2(hold_cycles_p + 1);
  localparam logic [cnt_w-1:0] hold_last_c = cnt_w'(hold_cycles_p - 1);
  localparam logic [cnt_w-1:0] hold_top_c  = cnt_w'(hold_cycles_p);

  if (sync_stages_p < qcl_reset_min_sync_stages_gp) begin : g_bad_sync
    $error("qcl_reset_sequencer: sync_stages_p below minimum");
  end
  if (hold_cycles_p < qcl_reset_min_hold_gp) begin : g_bad_hold
    $error("qcl_reset_sequencer: hold_cycles_p below minimum");
  end

  qcl_reset_state_e     state_q;
  logic [cnt_w-1:0]     cnt_q, cnt_d;
  logic [num_out_p-1:0] reset_q;
  logic                 done_q, ready_q, sync, sync_d;

  qcl_sync_chain #(.sync_stages_p(sync_stages_p)) u_sync (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .sync_o  (sync),
    .sync_d_o(sync_d)
  );

  assign cnt_d = (cnt_q == hold_top_c) ? cnt_q : cnt_q + cnt_w'(1);

`ifdef QCL_RESET_SEQ_STAGGER_EN
  localparam int stag_max_c = (num_out_p - 1) * stagger_p;
  localparam int scnt_w = $clog2(stag_max_c + 2);
  logic [scnt_w-1:0]    scnt_q, scnt_d;
  logic [num_out_p-1:0] stag_d;
  assign scnt_d = scnt_q + scnt_w'(1);
  always_comb begin
    stag_d = '0;
    for (int i = 0; i < num_out_p; i++)
      stag_d[i] = reset_q[i] & (32'(scnt_d) < 32'(i * stagger_p));
  end
`endif

  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) begin
      state_q <= RESET_S;
      cnt_q   <= '0;
      reset_q <= '1;
      done_q  <= 1'b0;
      ready_q <= 1'b0;
`ifdef QCL_RESET_SEQ_STAGGER_EN
      scnt_q  <= '0;
`endif
    end else begin
      case (state_q)
        // leave RESET on the very edge the synchronized reset falls
        RESET_S: if (sync && !sync_d) begin
          state_q <= HOLD_S;
          cnt_q   <= '0;
        end
        HOLD_S: begin
          cnt_q <= cnt_d;
          if (cnt_q == hold_last_c) begin
`ifdef QCL_RESET_SEQ_STAGGER_EN
            scnt_q  <= '0;
            reset_q <= {num_out_p{1'b1}} << 1;
            done_q  <= num_out_p == 1;
            ready_q <= num_out_p == 1;
            state_q <= (num_out_p == 1) ? RUN_S : STAGGER_S;
`else
            reset_q <= '0;
            done_q  <= 1'b1;
            ready_q <= 1'b1;
            state_q <= RUN_S;
`endif
          end
        end
`ifdef QCL_RESET_SEQ_STAGGER_EN
        STAGGER_S: begin
          scnt_q  <= scnt_d;
          reset_q <= stag_d;
          if (32'(scnt_d) == 32'(stag_max_c)) begin
            done_q  <= 1'b1;
            ready_q <= 1'b1;
            state_q <= RUN_S;
          end
        end
`endif
        RUN_S: if (sw_reset_v_i) begin
          state_q <= HOLD_S;
          cnt_q   <= '0;
          reset_q <= '1;
          done_q  <= 1'b0;
          ready_q <= 1'b0;
        end
        default: state_q <= RESET_S;
      endcase
    end

  assign reset_o          = reset_q;
  assign reset_done_o     = done_q;
  assign sw_reset_ready_o = ready_q;
endmodule

// File: tb/tb_qcl_reset_sequencer.sv
// tb_qcl_reset_sequencer: directed vectors for the reset sequencer, default and stagger builds.
// Main DUT: sync 2, hold 16, 3 outputs, stagger 4; corner DUT: sync 3, hold 1, 1 output.
module tb_qcl_reset_sequencer;
`ifdef QCL_RESET_SEQ_STAGGER_EN
  localparam bit stg = 1'b1;
`else
  localparam bit stg = 1'b0;
`endif
  localparam int last_off = stg ? 8 : 0;

  logic       clk = 1'b0;
  logic       rst = 1'b0, sw = 1'b0, rdy, done;
  logic [2:0] rout;
  logic       rst1 = 1'b0, sw1 = 1'b0, rdy1, done1;
  logic [0:0] rout1;
  int         nvec = 0, nerr = 0;

  always #5 clk = ~clk;

  qcl_reset_sequencer #(.sync_stages_p(2), .hold_cycles_p(16), .num_out_p(3), .stagger_p(4)) u0 (
    .clk_i(clk), .reset_i(rst), .sw_reset_v_i(sw), .sw_reset_ready_o(rdy),
    .reset_o(rout), .reset_done_o(done)
  );

  qcl_reset_sequencer #(.sync_stages_p(3), .hold_cycles_p(1), .num_out_p(1), .stagger_p(4)) u1 (
    .clk_i(clk), .reset_i(rst1), .sw_reset_v_i(sw1), .sw_reset_ready_o(rdy1),
    .reset_o(rout1), .reset_done_o(done1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] exp_rst(input int k, input int base);
    for (int i = 0; i < 3; i++) exp_rst[i] = k < base + (stg ? i * 4 : 0);
  endfunction

  // k counts edges: 1 = first edge after reset deassert, 0 = the sw accepting edge
  task automatic seq(input string tag, input int k0, input int base, input bit keep_sw);
    for (int k = k0; k <= base + last_off; k++) begin
      step();
      if (!keep_sw) sw = 1'b0;
      chk({tag, "_rst"}, 32'(rout), 32'(exp_rst(k, base)));
      chk({tag, "_done"}, 32'(done), 32'(k >= base + last_off));
      chk({tag, "_rdy"}, 32'(rdy), 32'(k >= base + last_off));
    end
    sw = 1'b0;
  endtask

  task automatic async_pulse(input string tag);
    #3 rst = 1'b1;
    #1;
    chk({tag, "_rst"}, 32'(rout), 32'd7);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_rdy"}, 32'(rdy), 32'd0);
    #1 rst = 1'b0;
  endtask

  initial begin
    #1 rst = 1'b1; rst1 = 1'b1;
    #1;
    chk("por_rst", 32'(rout), 32'd7);
    chk("por_done", 32'(done), 32'd0);
    chk("por_rdy", 32'(rdy), 32'd0);
    repeat (5) begin
      step();
      chk("por_hold", 32'(rout), 32'd7);
    end
    rst = 1'b0;
    seq("po", 1, 18, 1'b0);
    async_pulse("aa");
    seq("aa_rel", 1, 18, 1'b0);
    sw = 1'b1;
    seq("sw", 0, 16, 1'b0);
    sw = 1'b1;
    seq("swhold", 0, 16, 1'b1);
    sw = 1'b1;
    step();
    sw = 1'b0;
    repeat (8) begin
      step();
      chk("r8_hold", 32'(rout), 32'd7);
    end
    async_pulse("r8");
    sw = 1'b1;
    seq("r8_rel", 1, 18, 1'b1);
`ifdef QCL_RESET_SEQ_STAGGER_EN
    async_pulse("stg_pre");
    for (int k = 1; k <= 20; k++) begin
      step();
      chk("stg_part", 32'(rout), 32'(exp_rst(k, 18)));
    end
    async_pulse("stg20");
    seq("stg_rel", 1, 18, 1'b0);
`endif
    rst1 = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      step();
      chk("c_rst", 32'(rout1), 32'(k < 4));
      chk("c_done", 32'(done1), 32'(k >= 4));
      chk("c_rdy", 32'(rdy1), 32'(k >= 4));
    end
    sw1 = 1'b1;
    step();
    sw1 = 1'b0;
    chk("c_sw_rst", 32'(rout1), 32'd1);
    chk("c_sw_done", 32'(done1), 32'd0);
    step();
    chk("c_sw_rel", 32'(rout1), 32'd0);
    chk("c_sw_done2", 32'(done1), 32'd1);
    chk("c_sw_rdy", 32'(rdy1), 32'd1);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule

// File: doc/qcl_reset_sequencer.md
Name: qcl_reset_sequencer

Overview:
- Producer end of the team's synchronous-reset convention: turns the board/PLL asynchronous reset into a clean, synchronously released `reset_o` bus.
- That bus drives the `reset_i` of downstream qcl registers and pipelines.
- Asserts asynchronously and releases synchronously after a synchronizer chain plus a programmable hold window.
- Also accepts a valid/ready software reset request that re-runs the hold sequence without the board reset.

Parameters:
- sync_stages_p, 2: depth of the reset-release synchronizer; legal range is 2 or more.
- hold_cycles_p, 16: cycles `reset_o` stays high after the synchronized release or an accepted sw request; legal range is 1 or more.
- num_out_p, 1: number of reset outputs (downstream domains/blocks); legal range is 1 or more.
- stagger_p, 4: cycles between successive output releases; used only with the optional feature; legal range is 1 or more.

Ports:
- clk_i  input  1  single clock.
- reset_i  input  1  asynchronous, active-high reset; assertion needs no clock.
- sw_reset_v_i  input  1  software reset request valid.
- sw_reset_ready_o  output  1  request accepted on a cycle where `sw_reset_v_i & sw_reset_ready_o`.
- reset_o  output  num_out_p  synchronous active-high resets for downstream logic; bit i goes to consumer i.
- reset_done_o  output  1  high when every `reset_o` bit is low.

Behaviour:
- Reset values: `reset_o` = all ones, `reset_done_o` = 0, `sw_reset_ready_o` = 0, state = RESET, hold counter = 0, synchronizer chain = all ones.
- States:
  - RESET: synchronized reset is high.
  - HOLD: counting `hold_cycles_p`.
  - STAGGER: present only with the optional feature.
  - RUN.
- Asserting `reset_i`: asynchronous. All flops go to their reset values immediately, from any state, mid-HOLD and mid-STAGGER included. No glitch low on `reset_o`.
- Release of `reset_i`:
  - The chain shifts in 0. The synchronized reset falls on rising edge `sync_stages_p`, counting the first edge after deassertion as edge 1.
  - RESET to HOLD on that edge, counter loaded to 0.
  - HOLD increments the counter each cycle.
  - After `hold_cycles_p` HOLD cycles, go to RUN (no stagger).
  - Net release latency: `reset_o` falls on edge `sync_stages_p + hold_cycles_p`.
  - Deassertion inside the recovery window may shift this by exactly one cycle. Verification must accept ±1 only in that case.
- RUN:
  - `reset_o` = 0, `reset_done_o` = 1, `sw_reset_ready_o` = 1.
  - `sw_reset_ready_o` is 0 in every other state; `sw_reset_v_i` is ignored outside RUN, with no queuing.
- Software reset:
  - On the accepting edge the block moves to HOLD and the counter reloads.
  - From the next cycle: `reset_o` = all ones, `reset_done_o` = 0.
  - `reset_o` falls again `hold_cycles_p` cycles later. The sequence bypasses the synchronizer.
- Simultaneous `reset_i` and sw request: `reset_i` wins.
- Counter: width `$clog2(hold_cycles_p+1)`, with no wrap; it saturates at terminal count and the state leaves HOLD.
- All outputs except async assertion are registered; there is no combinational path from `sw_reset_v_i` to any output.

Optional Feature:
- Macro: `QCL_RESET_SEQ_STAGGER_EN`.
- Defined:
  - HOLD goes to STAGGER instead of RUN.
  - `reset_o[i]` falls `i*stagger_p` cycles after `reset_o[0]`. Bit 0 falls at the normal release edge.
  - Bits already released stay low.
  - STAGGER goes to RUN when bit `num_out_p-1` falls; `reset_done_o` rises with it.
  - A sw request is not accepted until RUN.
  - `reset_i` in STAGGER re-asserts all bits asynchronously.
- Undefined:
  - All bits release together; `stagger_p` is ignored and the STAGGER state is not generated.

Decomposition:
- Shared package `qcl_reset_pkg`:
  - state enum typedef (RESET/HOLD/STAGGER/RUN).
  - constants `qcl_reset_min_sync_stages_gp=2` and `qcl_reset_min_hold_gp=1`.
- Sub-module `qcl_sync_chain`:
  - width-1 synchronizer of `sync_stages_p` flops.
  - async set to 1 on `reset_i`, shifts in 0.
  - reusable for other reset release points.
- Elaboration-time assertions on the parameter minimums.

Test Plan (sync_stages_p=2, hold_cycles_p=16, num_out_p=3, stagger_p=4 unless noted):
- Power-on: `reset_i` high 5 cycles, then low.
  - Response: `reset_o`=3'b111 throughout; falls to 3'b000 on edge 18 after deassert; `reset_done_o`/`sw_reset_ready_o` rise on the same edge (no stagger).
- Async assert: in RUN, raise `reset_i` mid-cycle.
  - Response: `reset_o`=3'b111 and `reset_done_o`=0 before the next clock edge.
- SW reset: in RUN, one-cycle `sw_reset_v_i`=1.
  - Response: `reset_o`=3'b111 from the next cycle for 16 cycles, then 0; `sw_reset_ready_o`=0 throughout.
- Conflicts:
  - `sw_reset_v_i` held high during HOLD: no effect, and the counter is not restarted.
  - `reset_i` asserted on cycle 8 of HOLD: full 2+16 sequence restarts from deassert.
- Stagger (macro defined):
  - `reset_o[0]` falls on edge 18, `[1]` on edge 22, `[2]` on edge 26.
  - `reset_done_o` rises on edge 26.
  - `reset_i` pulse at edge 20 restores 3'b111 immediately.
- Param corner: `hold_cycles_p`=1, `sync_stages_p`=3 → release on edge 4; sw reset gives exactly 1 cycle of `reset_o` high.
